// File: rtl/sifive_occ_count_queue.sv
// Synchronous first-word-fall-through FIFO with a live 9-bit occupancy count,
// an almost-full flag, a sticky overflow flag and a same-cycle-safe flush.
module sifive_occ_count_queue #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 256,
    parameter int AFULL_THRESH = 240
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    input  logic             flush,
    output logic [8:0]       count,
    output logic             afull,
    output logic             overflow_err
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW:0]     PTR_ONE   = (AW+1)'(1);
    localparam logic [8:0]      AFULL_LVL = 9'(AFULL_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0] wptr, rptr;
    logic [AW:0] wptr_next, rptr_next;
    logic [8:0]  count_q, count_next;
    logic        ovf_q, ovf_next;

    logic empty, full;
    logic enq_fire, deq_fire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

    assign deq_bits     = mem[rptr[AW-1:0]];
    assign count        = count_q;
    assign afull        = (count_q >= AFULL_LVL);
    assign overflow_err = ovf_q;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wptr_next  = wptr;
        rptr_next  = rptr;
        count_next = count_q;
        ovf_next   = ovf_q;

        if (enq_fire) begin
            wptr_next = wptr + PTR_ONE;
        end

        // Flush discards stored entries but keeps a beat written this cycle.
        if (flush) begin
            rptr_next  = wptr;
            count_next = {8'd0, enq_fire};
        end else begin
            if (deq_fire) begin
                rptr_next = rptr + PTR_ONE;
            end
            count_next = count_q + {8'd0, enq_fire} - {8'd0, deq_fire};
        end

        if (enq_valid && full && !flush) begin
            ovf_next = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr    <= wptr_next;
            rptr    <= rptr_next;
            count_q <= count_next;
            ovf_q   <= ovf_next;
        end
    end

    // NOTE: storage has no reset; entries are only observable once a pointer
    // says they are valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            mem[wptr[AW-1:0]] <= enq_bits;
        end
    end

endmodule

// File: doc/sifive_occ_count_queue.md
Name: sifive_occ_count_queue

Overview:
- Synchronous FIFO with a live occupancy counter; the direct upstream producer of the 9-bit count and dequeue-valid signals consumed by the queue occupancy checker.
- Buffers request beats between a producer and a single consumer and reports exact occupancy every cycle.
- Raises an almost-full indication for early back-pressure.
- Supports a synchronous flush that empties the queue without losing the beat enqueued in the same cycle.

Parameters:
- WIDTH, 32, payload bits per entry
- DEPTH, 256, number of entries; must be a power of two, 2..256
- AFULL_THRESH, 240, count at or above which afull asserts; range 1..DEPTH

Ports:
- clock  in  1  sole clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- enq_valid  in  1  producer presents a beat
- enq_ready  out  1  queue can accept a beat
- enq_bits  in  WIDTH  producer payload
- deq_valid  out  1  head entry available
- deq_ready  in  1  consumer accepts the head
- deq_bits  out  WIDTH  head payload
- flush  in  1  synchronous discard of all stored entries
- count  out  9  current occupancy, 0..DEPTH
- afull  out  1  count >= AFULL_THRESH
- overflow_err  out  1  sticky; set when enq_valid is high while full and flush is low

Behaviour:
- Reset (reset_n low, asynchronous) clears wptr, rptr, count and overflow_err to 0. Outputs during and after reset:
  - enq_ready=1, deq_valid=0, count=0, afull=0, overflow_err=0
  - deq_bits is don't-care; storage is not reset
- Pointers: wptr and rptr are each log2(DEPTH)+1 bits. The MSB is the wrap bit.
  - empty = (wptr == rptr)
  - full = low bits equal and wrap bits differ
- Handshakes:
  - enq_fire = enq_valid & enq_ready
  - deq_fire = deq_valid & deq_ready
  - enq_ready = !full, combinational from state only; it does not depend on deq_ready, so there is no bypass at full.
  - deq_valid = !empty.
  - deq_bits = mem[rptr low bits], combinational read (first-word fall-through).
- Latency: a beat enqueued at edge N is visible on deq_valid/deq_bits in the cycle after edge N (1 cycle). There is no empty-queue bypass.
- count update: count_next = count + enq_fire - deq_fire, computed 9-bit.
  - Simultaneous enq_fire and deq_fire leaves count unchanged; both pointers advance.
  - count never exceeds DEPTH and never wraps below 0.
- Invariants the downstream checker relies on:
  - deq_valid implies count != 0.
  - count == DEPTH implies enq_ready == 0.
- afull: registered-equivalent, derived combinationally from count only.
- flush (highest priority over deq):
  - rptr <= wptr; a same-cycle enq_fire is still written and wptr advances.
  - count becomes 1 if enq_fire, else 0.
  - deq_fire is ignored in the flush cycle.
  - overflow_err is unaffected.
- overflow_err: set at the edge where enq_valid & full & !flush. It clears only on reset.
- Wrap-around: pointers wrap modulo 2*DEPTH; the data index wraps modulo DEPTH, seamlessly.
- Reset mid-operation: all queued beats are discarded immediately, with no partial handshake completion.

Test Plan:
- Reset, then enqueue 3 beats 0xA0,0xA1,0xA2 with deq_ready=0 -> count 1,2,3 on successive cycles; deq_bits=0xA0; deq_valid high from the cycle after the first enq.
- Fill to 256 with deq_ready=0 -> afull asserts at count=240; at count=256 enq_ready=0. Holding enq_valid one more cycle -> overflow_err=1 and stays 1; count stays 256.
- At count=256, pulse deq_ready for one cycle with enq_valid high -> count 255; next cycle enq_fire and deq_fire together -> count stays 255. Data order is preserved across the pointer wrap after 600 total beats.
- At count=5, assert flush with enq_valid=1, bits=0x55 -> next cycle count=1, deq_bits=0x55, overflow_err unchanged.
- Drop reset_n asynchronously mid-burst at count=17 -> count=0, deq_valid=0, enq_ready=1 before the next clock edge. The first post-reset beat emerges first.
- Random 10k-cycle traffic against a scoreboard -> no data mismatch; deq_valid never high with count==0; count always equals enqueued minus dequeued.
